// File: rtl/regbank_arbiter_if.sv
// Bus-slave strobes and the local requester handshake for regbank_arbiter.
// The master modport is the side that issues strobes and requests. The slave
// modport is the register bank arbiter itself.
interface regbank_arbiter_if #(
    parameter int DW = 3,
    parameter int AW = 2
);
    // Bus-slave side: 1-cycle strobes that can never be stalled
    logic          bus_do_read;
    logic          bus_do_write;
    logic [AW-1:0] bus_adr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    // Local fabric requester: req and its fields are held until ack
    logic          loc_req;
    logic          loc_we;
    logic [AW-1:0] loc_adr;
    logic [DW-1:0] loc_wdata;
    logic          loc_ack;
    logic [DW-1:0] loc_rdata;

    modport master (
        output bus_do_read, bus_do_write, bus_adr, bus_wdata,
        output loc_req, loc_we, loc_adr, loc_wdata,
        input  bus_rdata, loc_ack, loc_rdata
    );

    modport slave (
        input  bus_do_read, bus_do_write, bus_adr, bus_wdata,
        input  loc_req, loc_we, loc_adr, loc_wdata,
        output bus_rdata, loc_ack, loc_rdata
    );
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: a small register bank shared by the FSMC bus slave and one
// local fabric requester. Bus strobes always win. A local access waits in a
// one-deep slot and executes on the first cycle with no bus strobe.
// Optional feature: define REGBANK_READ_INC_EN to make every bus read
// post-increment the addressed register (modulo 2**DW).
module regbank_arbiter #(
    parameter  int DW   = 3,
    parameter  int AW   = 2,
    localparam int NREG = 2 ** AW
) (
    input  logic                clk,
    input  logic                nrst,
    regbank_arbiter_if.slave    bus,
    output logic [7:0]          defer_cnt,
    output logic [NREG*DW-1:0]  regs_flat
);

    // One-hot local access sequencer
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        PEND = 3'b010,
        ACK  = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] bank_q [NREG];
    logic [DW-1:0] bank_d [NREG];
    logic          slot_we_q, slot_we_d;
    logic [AW-1:0] slot_adr_q, slot_adr_d;
    logic [DW-1:0] slot_wdata_q, slot_wdata_d;
    logic [DW-1:0] loc_rdata_q, loc_rdata_d;
    logic [7:0]    defer_cnt_q, defer_cnt_d;

    logic bus_strobe;
    logic bus_wr_en;
    logic loc_exec;

    // A read strobe beats a simultaneous write strobe, so the write is dropped
    assign bus_strobe = bus.bus_do_read | bus.bus_do_write;
    assign bus_wr_en  = bus.bus_do_write & ~bus.bus_do_read;
    // The slot runs only on a cycle the bus leaves the bank alone
    assign loc_exec   = (state_q == PEND) && !bus_strobe;

    // Next-state logic for the local slot, deferral counter and read result
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_d      = state_q;
        slot_we_d    = slot_we_q;
        slot_adr_d   = slot_adr_q;
        slot_wdata_d = slot_wdata_q;
        loc_rdata_d  = loc_rdata_q;
        defer_cnt_d  = defer_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.loc_req) begin
                    slot_we_d    = bus.loc_we;
                    slot_adr_d   = bus.loc_adr;
                    slot_wdata_d = bus.loc_wdata;
                    state_d      = PEND;
                end
            end
            PEND: begin
                if (bus_strobe) begin
                    if (defer_cnt_q != 8'hFF) begin
                        defer_cnt_d = defer_cnt_q + 8'd1;
                    end
                end else begin
                    // The bank value from before this edge is returned
                    if (!slot_we_q) begin
                        loc_rdata_d = bank_q[slot_adr_q];
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bank update: a bus write or a read side effect, otherwise a local slot write
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (bus_wr_en) begin
            bank_d[bus.bus_adr] = bus.bus_wdata;
        end
`ifdef REGBANK_READ_INC_EN
        if (bus.bus_do_read) begin
            bank_d[bus.bus_adr] = bank_q[bus.bus_adr] + DW'(1);
        end
`else
`endif
        if (loc_exec && slot_we_q) begin
            bank_d[slot_adr_q] = slot_wdata_q;
        end
    end

    // State registers. An asynchronous reset discards any pending slot
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            slot_we_q    <= 1'b0;
            slot_adr_q   <= '0;
            slot_wdata_q <= '0;
            loc_rdata_q  <= '0;
            defer_cnt_q  <= 8'h00;
            // NOTE: the bank must read zero after reset, so it is built from flops with reset, not a RAM.
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            state_q      <= state_d;
            slot_we_q    <= slot_we_d;
            slot_adr_q   <= slot_adr_d;
            slot_wdata_q <= slot_wdata_d;
            loc_rdata_q  <= loc_rdata_d;
            defer_cnt_q  <= defer_cnt_d;
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign bus.bus_rdata = bank_q[bus.bus_adr];
    assign bus.loc_ack   = (state_q == ACK);
    assign bus.loc_rdata = loc_rdata_q;
    assign defer_cnt     = defer_cnt_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*DW +: DW] = bank_q[g];
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter. Local accesses push their expected
// result into a scoreboard queue, and a monitor pops the queue on each loc_ack.
module tb_regbank_arbiter;
    localparam int DW = 3;
    localparam int AW = 2;
`ifdef REGBANK_READ_INC_EN
    localparam bit READ_INC = 1'b1;
`else
    localparam bit READ_INC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  defer_cnt;
    logic [11:0] regs_flat;

    regbank_arbiter_if #(.DW(DW), .AW(AW)) ifc ();

    regbank_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (ifc),
        .defer_cnt (defer_cnt),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_read;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   ack_seen = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] reg_at(input int i);
        return regs_flat[i*DW +: DW];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [AW-1:0] adr, input logic [DW-1:0] wdata);
        ifc.bus_do_write = 1'b1;
        ifc.bus_adr      = adr;
        ifc.bus_wdata    = wdata;
        next_cycle();
        ifc.bus_do_write = 1'b0;
    endtask

    // Issue one local access, wait for its ack, then return the latency in cycles
    task automatic local_op(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_rdata, output int lat);
        exp_t e;
        e.is_read = !we;
        e.rdata   = exp_rdata;
        sb_q.push_back(e);
        ifc.loc_req   = 1'b1;
        ifc.loc_we    = we;
        ifc.loc_adr   = adr;
        ifc.loc_wdata = wdata;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (ifc.loc_ack) break;
            if (lat >= 1000) begin
                check("ack_timeout", 32'(ifc.loc_ack), 32'd1);
                void'(sb_q.pop_back());
                break;
            end
            next_cycle();
            lat++;
        end
        ifc.loc_req = 1'b0;
        next_cycle();
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding request
    always @(negedge clk) begin : mon
        exp_t e;
        if (nrst && ifc.loc_ack) begin
            ack_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(ifc.loc_ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.is_read) check("loc_rdata", 32'(ifc.loc_rdata), 32'(e.rdata));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int ack_before;

        ifc.bus_do_read  = 1'b0;
        ifc.bus_do_write = 1'b0;
        ifc.bus_adr      = '0;
        ifc.bus_wdata    = '0;
        ifc.loc_req      = 1'b0;
        ifc.loc_we       = 1'b0;
        ifc.loc_adr      = '0;
        ifc.loc_wdata    = '0;

        // Reset state
        #12;
        check("rst_regs", 32'(regs_flat), 32'd0);
        check("rst_defer", 32'(defer_cnt), 32'd0);
        check("rst_ack", 32'(ifc.loc_ack), 32'd0);
        check("rst_rdata", 32'(ifc.loc_rdata), 32'd0);
        next_cycle();
        nrst = 1'b1;
        next_cycle();

        // 1: bus write shows up in the bank and on bus_rdata
        bus_write(2'd2, 3'd5);
        @(negedge clk);
        check("t1_reg2", 32'(reg_at(2)), 32'd5);
        check("t1_rdata", 32'(ifc.bus_rdata), 32'd5);
        next_cycle();

        // 2: local write on an idle bus, minimum latency
        local_op(1'b1, 2'd1, 3'd3, 3'd0, lat);
        check("t2_lat", 32'(lat), 32'd2);
        check("t2_reg1", 32'(reg_at(1)), 32'd3);
        check("t2_defer", 32'(defer_cnt), 32'd0);

        // 3: local read deferred by three back-to-back bus writes to the same address
        fork
            local_op(1'b0, 2'd0, 3'd0, 3'd4, lat);
            begin
                next_cycle();
                ifc.bus_do_write = 1'b1;
                ifc.bus_adr      = 2'd0;
                ifc.bus_wdata    = 3'd1;
                next_cycle();
                ifc.bus_wdata    = 3'd2;
                next_cycle();
                ifc.bus_wdata    = 3'd4;
                next_cycle();
                ifc.bus_do_write = 1'b0;
            end
        join
        check("t3_lat", 32'(lat), 32'd5);
        check("t3_defer", 32'(defer_cnt), 32'd3);
        check("t3_reg0", 32'(reg_at(0)), 32'd4);
        next_cycle();
        next_cycle();
        check("t3_rdata_held", 32'(ifc.loc_rdata), 32'd4);

        // Frozen slot, and a local write lands after a bus write to the same address
        fork
            local_op(1'b1, 2'd2, 3'd6, 3'd0, lat);
            begin
                next_cycle();
                ifc.bus_do_write = 1'b1;
                ifc.bus_adr      = 2'd2;
                ifc.bus_wdata    = 3'd1;
                ifc.loc_wdata    = 3'd5;
                ifc.loc_adr      = 2'd3;
                next_cycle();
                ifc.bus_do_write = 1'b0;
            end
        join
        check("frz_lat", 32'(lat), 32'd3);
        check("frz_reg2", 32'(reg_at(2)), 32'd6);
        check("frz_reg3", 32'(reg_at(3)), 32'd0);
        check("frz_defer", 32'(defer_cnt), 32'd4);

        // A local read never increments, in either build
        local_op(1'b0, 2'd1, 3'd0, 3'd3, lat);
        check("lrd_reg1", 32'(reg_at(1)), 32'd3);

        // 4: a bus read shows the old value and wraps 7 to 0 when the increment is built in
        bus_write(2'd3, 3'd7);
        ifc.bus_do_read = 1'b1;
        ifc.bus_adr     = 2'd3;
        @(negedge clk);
        check("t4_rdata", 32'(ifc.bus_rdata), 32'd7);
        next_cycle();
        ifc.bus_do_read = 1'b0;
        @(negedge clk);
        check("t4_reg3", 32'(reg_at(3)), READ_INC ? 32'd0 : 32'd7);
        next_cycle();

        // 5: both strobes in one cycle, the write is dropped
        bus_write(2'd1, 3'd2);
        ifc.bus_do_read  = 1'b1;
        ifc.bus_do_write = 1'b1;
        ifc.bus_adr      = 2'd1;
        ifc.bus_wdata    = 3'd6;
        next_cycle();
        ifc.bus_do_read  = 1'b0;
        ifc.bus_do_write = 1'b0;
        @(negedge clk);
        check("t5_reg1", 32'(reg_at(1)), READ_INC ? 32'd3 : 32'd2);
        next_cycle();

        // 6a: reset while a slot is pending clears everything, and no ack follows
        ifc.loc_req   = 1'b1;
        ifc.loc_we    = 1'b1;
        ifc.loc_adr   = 2'd0;
        ifc.loc_wdata = 3'd7;
        next_cycle();
        ack_before = ack_seen;
        #2;
        nrst = 1'b0;
        #1;
        check("t6_regs", 32'(regs_flat), 32'd0);
        check("t6_defer", 32'(defer_cnt), 32'd0);
        check("t6_ack", 32'(ifc.loc_ack), 32'd0);
        check("t6_rdata", 32'(ifc.loc_rdata), 32'd0);
        ifc.loc_req = 1'b0;
        next_cycle();
        next_cycle();
        nrst = 1'b1;
        repeat (4) next_cycle();
        check("t6_no_ack", 32'(ack_seen), 32'(ack_before));
        check("t6_regs_after", 32'(regs_flat), 32'd0);

        // 6b: 300 cycles of bus strobes while a local write waits saturate defer_cnt
        fork
            local_op(1'b1, 2'd0, 3'd2, 3'd0, lat);
            begin
                ifc.bus_do_write = 1'b1;
                ifc.bus_adr      = 2'd3;
                ifc.bus_wdata    = 3'd5;
                repeat (300) next_cycle();
                ifc.bus_do_write = 1'b0;
            end
        join
        check("sat_defer", 32'(defer_cnt), 32'd255);
        check("sat_lat", 32'(lat), 32'd301);
        check("sat_reg0", 32'(reg_at(0)), 32'd2);
        check("sat_reg3", 32'(reg_at(3)), 32'd5);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
